// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between instruction fetch and load/store.
// Data has fixed priority; a streak limit bounds how long a pending fetch can be starved.
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } gnt_e;

  gnt_e                gnt;
  logic                ifv;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rsp_if_q, rsp_if_d;
  logic                rsp_d_q, rsp_d_d;
  logic                rsp_dwe_q, rsp_dwe_d;

  // Only the word-address bits reach the SRAM; byte offset and upper bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    ifv = if_req_i & ~if_flush_i;
    gnt = GNT_NONE;
    if (!rst_i) begin
      gnt = GNT_NONE;
    end else if (d_req_i && !(ifv && (streak_q == STREAK_MAX))) begin
      gnt = GNT_D;
    end else if (ifv) begin
      gnt = GNT_IF;
    end
  end

  always_comb begin
    if_gnt_o    = (gnt == GNT_IF);
    d_gnt_o     = (gnt == GNT_D);
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (gnt)
      GNT_D: begin
        mem_en_o    = 1'b1;
        mem_we_o    = d_we_i;
        mem_be_o    = d_we_i ? d_be_i : 4'hF;
        mem_addr_o  = d_addr_i[ADDR_W+1:2];
        mem_wdata_o = d_wdata_i;
      end
      GNT_IF: begin
        mem_en_o   = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = if_addr_i[ADDR_W+1:2];
      end
      default: ;
    endcase
  end

  // Streak only counts data grants that actually made a live fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (!ifv || gnt == GNT_IF) begin
      streak_d = '0;
    end else if (gnt == GNT_D && streak_q != STREAK_MAX) begin
      streak_d = streak_q + STREAK_W'(1);
    end
    rsp_if_d  = if_gnt_o;
    rsp_d_d   = d_gnt_o;
    rsp_dwe_d = d_gnt_o & d_we_i;
  end

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      streak_q  <= '0;
      rsp_if_q  <= 1'b0;
      rsp_d_q   <= 1'b0;
      rsp_dwe_q <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      rsp_if_q  <= rsp_if_d;
      rsp_d_q   <= rsp_d_d;
      rsp_dwe_q <= rsp_dwe_d;
    end
  end

  // A redirect in the response cycle discards the fetched word.
  always_comb begin
    if_rvalid_o = rsp_if_q & ~if_flush_i;
    d_rvalid_o  = rsp_d_q;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    d_rdata_o   = (rsp_d_q & ~rsp_dwe_q) ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a rule-level model with its own golden memory image.
module tb_imem_dmem_arbiter;

  localparam int ADDR_W = 12;
  localparam int MAX_D  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              if_req_i, if_flush_i;
  logic [31:0]       if_addr_i;
  logic              if_gnt_o, if_rvalid_o;
  logic [31:0]       if_rdata_o;
  logic              d_req_i, d_we_i;
  logic [3:0]        d_be_i;
  logic [31:0]       d_addr_i, d_wdata_i;
  logic              d_gnt_o, d_rvalid_o;
  logic [31:0]       d_rdata_o;
  logic              mem_en_o, mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // SRAM attached to the DUT, and an independent golden image the model reads from.
  logic [31:0] sram [DEPTH];
  logic [31:0] gold [DEPTH];
  logic [31:0] sram_rdata_q = 32'h0;
  assign mem_rdata_i = sram_rdata_q;

  function automatic logic [31:0] init_word(input int i);
    return (i == 32'h10) ? 32'h0050_0093 : (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_q <= sram[mem_addr_o];
      end
    end
  end

  // Behavioural model: grant decision from the rules, responses from the golden image.
  logic        model_on = 1'b0;
  logic        last_if_gnt = 1'b0, last_d_gnt = 1'b0;
  int          m_streak = 0;
  logic        m_rsp_if = 1'b0, m_rsp_d = 1'b0, m_rsp_dwe = 1'b0;
  logic [31:0] m_if_data = 32'h0, m_d_data = 32'h0;
  logic        ifv, e_if, e_d, e_en;
  logic [3:0]  e_be;
  logic [11:0] e_addr;
  int          a;

  always @(negedge clk) begin
    if (model_on) begin
      ifv    = if_req_i && !if_flush_i;
      e_d    = rst_i && d_req_i && !(ifv && m_streak == MAX_D);
      e_if   = rst_i && !e_d && ifv;
      e_en   = e_d || e_if;
      e_be   = e_d ? (d_we_i ? d_be_i : 4'hF) : (e_if ? 4'hF : 4'h0);
      e_addr = e_d ? d_addr_i[13:2] : (e_if ? if_addr_i[13:2] : 12'h0);

      check("if_gnt", 32'(if_gnt_o), 32'(e_if));
      check("d_gnt", 32'(d_gnt_o), 32'(e_d));
      check("mem_en", 32'(mem_en_o), 32'(e_en));
      check("mem_we", 32'(mem_we_o), 32'(e_d && d_we_i));
      check("mem_be", 32'(mem_be_o), 32'(e_be));
      check("mem_addr", 32'(mem_addr_o), 32'(e_addr));
      if (!e_en || (e_d && d_we_i)) check("mem_wdata", mem_wdata_o, e_d ? d_wdata_i : 32'h0);
      check("if_rvalid", 32'(if_rvalid_o), 32'(m_rsp_if && !if_flush_i));
      check("if_rdata", if_rdata_o, (m_rsp_if && !if_flush_i) ? m_if_data : 32'h0);
      check("d_rvalid", 32'(d_rvalid_o), 32'(m_rsp_d));
      check("d_rdata", d_rdata_o, (m_rsp_d && !m_rsp_dwe) ? m_d_data : 32'h0);

      if (!rst_i || !ifv || e_if) m_streak = 0;
      else if (e_d) m_streak = (m_streak < MAX_D) ? m_streak + 1 : MAX_D;
      m_rsp_if  = e_if;
      m_rsp_d   = e_d;
      m_rsp_dwe = e_d && d_we_i;
      a = int'(e_addr);
      if (e_if) m_if_data = gold[a];
      if (e_d && !d_we_i) m_d_data = gold[a];
      if (e_d && d_we_i)
        for (int b = 0; b < 4; b++)
          if (d_be_i[b]) gold[a][b*8 +: 8] = d_wdata_i[b*8 +: 8];
      last_if_gnt = e_if;
      last_d_gnt  = e_d;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = init_word(i);
      gold[i] = init_word(i);
    end
    rst_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h40; if_flush_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h200; d_wdata_i = 32'h0;
    step();
    model_on = 1'b1;

    // Reset held with both requests pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_if_gnt", 32'(if_gnt_o), 0);
      check("rst_d_gnt", 32'(d_gnt_o), 0);
      check("rst_mem_en", 32'(mem_en_o), 0);
      check("rst_rvalids", 32'({if_rvalid_o, d_rvalid_o}), 0);
      step();
    end
    rst_i = 1'b1;
    @(negedge clk);
    check("rel_d_gnt", 32'(d_gnt_o), 1);
    check("rel_if_gnt", 32'(if_gnt_o), 0);
    step();
    d_req_i = 1'b0;
    @(negedge clk);
    check("fetch_gnt", 32'(if_gnt_o), 1);
    check("fetch_addr", 32'(mem_addr_o), 32'h10);
    step();
    if_req_i = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", 32'(if_rvalid_o), 1);
    check("fetch_rdata", if_rdata_o, 32'h0050_0093);

    // Store then load to 0x100.
    step();
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("st_mem_we", 32'(mem_we_o), 1);
    check("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    step();
    d_we_i = 1'b0; d_be_i = 4'h0;
    @(negedge clk);
    check("st_ack", 32'(d_rvalid_o), 1);
    check("st_ack_rdata", d_rdata_o, 0);
    step();
    d_req_i = 1'b0;
    @(negedge clk);
    check("ld_rvalid", 32'(d_rvalid_o), 1);
    check("ld_rdata_lo", 32'(d_rdata_o[15:0]), 32'hBEEF);

    // Starvation bound with both requests held.
    step();
    if_req_i = 1'b1; if_addr_i = 32'h80; d_req_i = 1'b1; d_addr_i = 32'h104;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("starve_d%0d", i), 32'(d_gnt_o), 32'(pat[i]));
      check($sformatf("starve_if%0d", i), 32'(if_gnt_o), 32'(!pat[i]));
      step();
    end
    d_req_i = 1'b0; if_req_i = 1'b0;

    // Flush in the response cycle of a fetch.
    step();
    if_req_i = 1'b1; if_addr_i = 32'h44;
    @(negedge clk);
    check("fl_gnt_n", 32'(if_gnt_o), 1);
    step();
    if_flush_i = 1'b1;
    @(negedge clk);
    check("fl_rvalid", 32'(if_rvalid_o), 0);
    check("fl_gnt_n1", 32'(if_gnt_o), 0);
    check("fl_rdata", if_rdata_o, 0);
    step();
    if_flush_i = 1'b0; if_req_i = 1'b0;

    // Reset against an issuing load, and against an outstanding load.
    step();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h108; rst_i = 1'b0;
    @(negedge clk);
    check("rl_gnt_blocked", 32'(d_gnt_o), 0);
    step();
    rst_i = 1'b1; d_req_i = 1'b0;
    @(negedge clk);
    check("rl_no_rvalid", 32'(d_rvalid_o), 0);
    step();
    d_req_i = 1'b1; d_addr_i = 32'h10C;
    @(negedge clk);
    check("rl2_gnt", 32'(d_gnt_o), 1);
    step();
    rst_i = 1'b0; d_req_i = 1'b0;
    step();
    rst_i = 1'b1;
    @(negedge clk);
    check("rl2_discard", 32'(d_rvalid_o), 0);

    // Random traffic; requests and their fields stay put until granted.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_i      = ($urandom_range(99) != 0);
      if_flush_i = ($urandom_range(9) == 0);
      if (!if_req_i || last_if_gnt || if_flush_i) begin
        if_req_i  = ($urandom_range(3) != 0);
        if_addr_i = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(63)) << 2)
                    | 32'($urandom_range(3));
      end
      if (!d_req_i || last_d_gnt) begin
        d_req_i   = ($urandom_range(2) != 0);
        d_we_i    = $urandom_range(1) == 1;
        d_be_i    = 4'($urandom_range(15));
        d_addr_i  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(63)) << 2)
                    | 32'($urandom_range(3));
        d_wdata_i = $urandom;
      end
    end
    step();
    if_req_i = 1'b0; d_req_i = 1'b0; if_flush_i = 1'b0; rst_i = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
